math_round_ctrl: RTL

//  Game sequencer for the addition quiz; consumes the free-running 5-bit LFSR value.

---
 rtl/math_round_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/math_round_ctrl.sv
// rtl/math_round_ctrl.sv - addition quiz round sequencer: operand capture, display timing, answer check
// Every output comes from a flop; displayed values are computed from next-state so they track the state.
module math_round_ctrl #(
    parameter int RND_W       = 5,
    parameter int SHOW_CYC    = 25000000,
    parameter int TIMEOUT_CYC = 250000000,
    parameter int ROUNDS      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RND_W-1:0] rnd_in,
    input  logic             start,
    input  logic             submit,
    input  logic [7:0]       answer,
    output logic [7:0]       disp_value,
    output logic [6:0]       led,
    output logic [3:0]       score,
    output logic [3:0]       round_num,
    output logic             correct,
    output logic             wrong,
    output logic             game_over
);

    localparam int MAX_CYC = (SHOW_CYC > TIMEOUT_CYC) ? SHOW_CYC : TIMEOUT_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GEN    = 3'd1,
        S_SHOW_A = 3'd2,
        S_SHOW_B = 3'd3,
        S_ANSWER = 3'd4,
        S_RESULT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [7:0]    op_a_q, op_a_n;
    logic [7:0]    op_b_q, op_b_n;
    logic [3:0]    score_q, score_n;
    logic [3:0]    round_q, round_n;
    logic [7:0]    disp_q, disp_n;
    logic          correct_q, correct_n;
    logic          wrong_q, wrong_n;
    logic          over_q, over_n;
    logic [8:0]    sum;
    logic [7:0]    res_n;
    logic          show_end;
    logic          timeout_end;

    assign sum         = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign show_end    = (timer_q == TW'(SHOW_CYC - 1));
    assign timeout_end = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q + 1'b1;
        op_a_n    = op_a_q;
        op_b_n    = op_b_q;
        score_n   = score_q;
        round_n   = round_q;
        correct_n = 1'b0;
        wrong_n   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                timer_n = '0;
                if (start) begin
                    state_n = S_GEN;
                    score_n = 4'd0;
                    round_n = 4'd1;
                end
            end
            S_GEN: begin
                if (timer_q == '0) begin
                    op_a_n = 8'(rnd_in);
                end else begin
                    op_b_n  = 8'(rnd_in);
                    state_n = S_SHOW_A;
                end
            end
            S_SHOW_A: begin
                if (show_end) state_n = S_SHOW_B;
            end
            S_SHOW_B: begin
                if (show_end) state_n = S_ANSWER;
            end
            S_ANSWER: begin
                // submit takes priority over a coincident timeout
                if (submit) begin
                    state_n = S_RESULT;
                    if ({1'b0, answer} == sum) begin
                        correct_n = 1'b1;
                        score_n   = score_q + 4'd1;
                    end else begin
                        wrong_n = 1'b1;
                    end
                end else if (timeout_end) begin
                    state_n = S_RESULT;
                    wrong_n = 1'b1;
                end
            end
            S_RESULT: begin
                if (show_end) begin
                    if (round_q == 4'(ROUNDS)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_GEN;
                        round_n = round_q + 4'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase

        if (state_n != state_q) timer_n = '0;
    end

    assign res_n = op_a_n + op_b_n;

    always_comb begin
        disp_n = 8'd0;
        case (state_n)
            S_SHOW_A: disp_n = op_a_n;
            S_SHOW_B: disp_n = op_b_n;
            S_ANSWER: disp_n = answer;
            S_RESULT: disp_n = res_n;
            S_DONE:   disp_n = {4'd0, score_n};
            default:  disp_n = 8'd0;
        endcase
        over_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            op_a_q    <= 8'd0;
            op_b_q    <= 8'd0;
            score_q   <= 4'd0;
            round_q   <= 4'd0;
            disp_q    <= 8'd0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            op_a_q    <= op_a_n;
            op_b_q    <= op_b_n;
            score_q   <= score_n;
            round_q   <= round_n;
            disp_q    <= disp_n;
            correct_q <= correct_n;
            wrong_q   <= wrong_n;
            over_q    <= over_n;
        end
    end

    assign disp_value = disp_q;
    assign led        = {state_q, score_q};
    assign score      = score_q;
    assign round_num  = round_q;
    assign correct    = correct_q;
    assign wrong      = wrong_q;
    assign game_over  = over_q;

endmodule
